// File: rtl/regfile_sb_pkg.sv
// rtl/regfile_sb_pkg.sv - shared constants and types for the scoreboarded register file
//
// Purpose : default data/address geometry, the architectural zero register
//           index and the read-source classification used by the read muxes.
// Ports   : none (package)
package regfile_sb_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;
    localparam int REG_ZERO = 0;

    // Where a read port takes its result from in the current cycle.
    typedef enum logic [1:0] {
        RD_ZERO_OK = 2'd0,  // port idle or x0: data 0, operand ready
        RD_STORED  = 2'd1,  // no pending writer: stored word
        RD_BYPASS  = 2'd2,  // last pending writer retiring now: forwarded data
        RD_STALL   = 2'd3   // operand not yet available
    } rd_src_e;

endpackage

// File: rtl/regfile_sb_cnt.sv
// rtl/regfile_sb_cnt.sv - pending-write counter for one architectural register
//
// Purpose : tracks how many issued-but-not-written-back producers target
//           this register; increments on accepted issue, decrements by the
//           number of write-back hits, floors at zero, clears on flush.
// Ports   : clk_in, rst_n_in      clock / async active-low reset
//           inc_in                accepted issue to this register
//           dec_in  [DW-1:0]      number of write-back ports hitting it
//           flush_in              discard tracking
//           pcnt_out[CNT_W-1:0]   current pending count
module regfile_sb_cnt
    import regfile_sb_pkg::*;
#(
    parameter int CNT_W = 2,
    parameter int DW    = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             inc_in,
    input  logic [DW-1:0]    dec_in,
    input  logic             flush_in,
    output logic [CNT_W-1:0] pcnt_out
);

    localparam int SW = ((CNT_W > DW) ? CNT_W : DW) + 1;

    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] pcnt_d;
    logic [SW-1:0]    sum;

    // Issue is never accepted at MAX, so sum cannot exceed MAX; the floor
    // covers write-backs that outnumber the tracked producers.
    always_comb begin
        sum    = SW'(pcnt_q) + SW'(inc_in);
        pcnt_d = '0;
        if (!flush_in && (sum > SW'(dec_in))) begin
            pcnt_d = CNT_W'(sum - SW'(dec_in));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end

    assign pcnt_out = pcnt_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-ported register file with per-register pending-write scoreboard
//
// Purpose : NREG x XLEN register file, NWP write-back ports, NRP combinational
//           read ports reporting operand readiness, and an issue interface that
//           is back-pressured when a register's pending counter is saturated.
//           Optional same-cycle write-back forwarding under REGFILE_SB_BYPASS_EN.
// Ports   : clk_in, rst_n_in                     clock / async active-low reset
//           wb_we_in, wb_addr_in, wb_data_in     write-back ports (port 0 in LSBs)
//           iss_valid_in, iss_rd_in, iss_ready_out  destination issue handshake
//           flush_in                             drop all pending tracking
//           rd_en_in, rd_addr_in                 read requests
//           rd_data_out, rd_ok_out               read data / operand ready
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter  int XLEN  = DEF_XLEN,
    parameter  int NREG  = DEF_NREG,
    parameter  int NRP   = 2,
    parameter  int NWP   = 2,
    parameter  int CNT_W = 2,
    localparam int AW    = $clog2(NREG)
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [NWP-1:0]      wb_we_in,
    input  logic [NWP*AW-1:0]   wb_addr_in,
    input  logic [NWP*XLEN-1:0] wb_data_in,
    input  logic                iss_valid_in,
    input  logic [AW-1:0]       iss_rd_in,
    output logic                iss_ready_out,
    input  logic                flush_in,
    input  logic [NRP-1:0]      rd_en_in,
    input  logic [NRP*AW-1:0]   rd_addr_in,
    output logic [NRP*XLEN-1:0] rd_data_out,
    output logic [NRP-1:0]      rd_ok_out
);

    localparam int               DW  = $clog2(NWP + 1);
    localparam logic [CNT_W-1:0] MAX = '1;

    logic [XLEN-1:0]  mem_q  [NREG];
    logic [XLEN-1:0]  mem_d  [NREG];
    logic [CNT_W-1:0] pcnt   [NREG];
    logic [AW-1:0]    wb_addr [NWP];
    logic [XLEN-1:0]  wb_data [NWP];
    logic [XLEN-1:0]  rd_data [NRP];
    logic             rd_ok   [NRP];
    logic             iss_accept;

    always_comb begin
        for (int p = 0; p < NWP; p++) begin
            wb_addr[p] = wb_addr_in[p*AW +: AW];
            wb_data[p] = wb_data_in[p*XLEN +: XLEN];
        end
    end

    // x0 is never tracked, so it is always ready.
    always_comb begin
        iss_ready_out = rst_n_in &&
                        ((pcnt[iss_rd_in] != MAX) || (iss_rd_in == AW'(REG_ZERO)));
        iss_accept    = iss_valid_in && iss_ready_out && !flush_in;
    end

    for (genvar r = 0; r < NREG; r++) begin : g_cnt
        logic [DW-1:0] dec;
        logic          inc;

        always_comb begin
            dec = '0;
            for (int p = 0; p < NWP; p++) begin
                if (wb_we_in[p] && (wb_addr[p] == AW'(r)) && (r != REG_ZERO)) begin
                    dec = dec + DW'(1);
                end
            end
            inc = iss_accept && (iss_rd_in == AW'(r)) && (r != REG_ZERO);
        end

        regfile_sb_cnt #(
            .CNT_W (CNT_W),
            .DW    (DW)
        ) u_cnt (
            .clk_in   (clk_in),
            .rst_n_in (rst_n_in),
            .inc_in   (inc),
            .dec_in   (dec),
            .flush_in (flush_in),
            .pcnt_out (pcnt[r])
        );
    end

    // Ascending port order lets the highest-index port win on an address clash.
    always_comb begin
        mem_d = mem_q;
        for (int p = 0; p < NWP; p++) begin
            if (wb_we_in[p] && (wb_addr[p] != AW'(REG_ZERO))) begin
                mem_d[wb_addr[p]] = wb_data[p];
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int r = 0; r < NREG; r++) begin
                mem_q[r] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    for (genvar i = 0; i < NRP; i++) begin : g_rd
        logic [AW-1:0] addr;
        logic          hit;
        rd_src_e       src;
`ifdef REGFILE_SB_BYPASS_EN
        logic [XLEN-1:0] hit_data;
`endif

        always_comb begin
            addr = rd_addr_in[i*AW +: AW];
            hit  = 1'b0;
`ifdef REGFILE_SB_BYPASS_EN
            hit_data = '0;
`endif
            for (int p = 0; p < NWP; p++) begin
                if (wb_we_in[p] && (wb_addr[p] == addr)) begin
                    hit = 1'b1;
`ifdef REGFILE_SB_BYPASS_EN
                    hit_data = wb_data[p];
`endif
                end
            end

            if (!rd_en_in[i] || (addr == AW'(REG_ZERO))) begin
                src = RD_ZERO_OK;
            end else if ((pcnt[addr] == '0) && !hit) begin
                src = RD_STORED;
`ifdef REGFILE_SB_BYPASS_EN
            end else if (hit && (pcnt[addr] <= CNT_W'(1))) begin
                src = RD_BYPASS;
`endif
            end else begin
                src = RD_STALL;
            end

            rd_data[i] = '0;
            rd_ok[i]   = 1'b0;
            if (rst_n_in) begin
                case (src)
                    RD_ZERO_OK: rd_ok[i] = 1'b1;
                    RD_STORED: begin
                        rd_data[i] = mem_q[addr];
                        rd_ok[i]   = 1'b1;
                    end
`ifdef REGFILE_SB_BYPASS_EN
                    RD_BYPASS: begin
                        rd_data[i] = hit_data;
                        rd_ok[i]   = 1'b1;
                    end
`endif
                    default: rd_ok[i] = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NRP; i++) begin
            rd_data_out[i*XLEN +: XLEN] = rd_data[i];
            rd_ok_out[i]                = rd_ok[i];
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - scoreboard bench for regfile_sb
module tb_regfile_sb;

    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NRP   = 2;
    localparam int NWP   = 2;
    localparam int CNT_W = 2;
    localparam int AW    = 5;
`ifdef REGFILE_SB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                clk_in;
    logic                rst_n_in;
    logic [NWP-1:0]      wb_we_in;
    logic [NWP*AW-1:0]   wb_addr_in;
    logic [NWP*XLEN-1:0] wb_data_in;
    logic                iss_valid_in;
    logic [AW-1:0]       iss_rd_in;
    logic                iss_ready_out;
    logic                flush_in;
    logic [NRP-1:0]      rd_en_in;
    logic [NRP*AW-1:0]   rd_addr_in;
    logic [NRP*XLEN-1:0] rd_data_out;
    logic [NRP-1:0]      rd_ok_out;

    typedef struct {
        string           name;
        int              port;  // NRP selects iss_ready_out
        logic [XLEN-1:0] data;
        logic            ok;
    } exp_t;

    exp_t            sb[$];
    exp_t            e;
    logic [XLEN-1:0] act_d;
    logic            act_ok;
    int              checks   = 0;
    int              failures = 0;

    regfile_sb #(
        .XLEN  (XLEN),
        .NREG  (NREG),
        .NRP   (NRP),
        .NWP   (NWP),
        .CNT_W (CNT_W)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .wb_we_in      (wb_we_in),
        .wb_addr_in    (wb_addr_in),
        .wb_data_in    (wb_data_in),
        .iss_valid_in  (iss_valid_in),
        .iss_rd_in     (iss_rd_in),
        .iss_ready_out (iss_ready_out),
        .flush_in      (flush_in),
        .rd_en_in      (rd_en_in),
        .rd_addr_in    (rd_addr_in),
        .rd_data_out   (rd_data_out),
        .rd_ok_out     (rd_ok_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic idle();
        wb_we_in     = '0;
        wb_addr_in   = '0;
        wb_data_in   = '0;
        iss_valid_in = 1'b0;
        iss_rd_in    = '0;
        flush_in     = 1'b0;
        rd_en_in     = '0;
        rd_addr_in   = '0;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d,
                      input logic ok, input string n);
        rd_en_in[p]            = 1'b1;
        rd_addr_in[p*AW +: AW] = a;
        sb.push_back('{name: n, port: p, data: d, ok: ok});
    endtask

    task automatic no_rd(input int p, input string n);
        rd_en_in[p]            = 1'b0;
        rd_addr_in[p*AW +: AW] = 5'd9;
        sb.push_back('{name: n, port: p, data: '0, ok: 1'b1});
    endtask

    task automatic ready(input logic [AW-1:0] a, input logic ok, input string n);
        iss_rd_in = a;
        sb.push_back('{name: n, port: NRP, data: '0, ok: ok});
    endtask

    task automatic issue(input logic [AW-1:0] a);
        iss_valid_in = 1'b1;
        iss_rd_in    = a;
    endtask

    task automatic wb(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wb_we_in[p]                = 1'b1;
        wb_addr_in[p*AW +: AW]     = a;
        wb_data_in[p*XLEN +: XLEN] = d;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_in); #1;
            idle();
            if (k == 1) rst_n_in = 1'b1;
            case (k)
                0: begin
                    rd(0, 5'd5, 32'h0, 1'b0, "rst_x5");
                    rd(1, 5'd0, 32'h0, 1'b0, "rst_x0");
                    ready(5'd5, 1'b0, "rst_ready");
                end
                default: begin
                    rd(0, 5'd5, 32'h0, 1'b1, "post_rst_x5");
                    no_rd(1, "rd_en_low");
                    ready(5'd5, 1'b1, "post_rst_ready");
                end
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    task automatic test_issue_wb();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            idle();
            case (k)
                0: begin issue(5'd3); ready(5'd3, 1'b1, "x3_ready"); end
                1: rd(0, 5'd3, 32'h0, 1'b0, "x3_pending");
                2: begin
                    wb(0, 5'd3, 32'hDEADBEEF);
                    rd(0, 5'd3, BYP ? 32'hDEADBEEF : 32'h0, BYP, "x3_same_cycle_wb");
                    rd(1, 5'd5, 32'h0, 1'b1, "x5_other_port");
                end
                default: rd(0, 5'd3, 32'hDEADBEEF, 1'b1, "x3_after_wb");
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    task automatic test_multi_wb();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            idle();
            case (k)
                0: begin
                    wb(0, 5'd7, 32'h11);
                    wb(1, 5'd7, 32'h22);
                    rd(0, 5'd7, BYP ? 32'h22 : 32'h0, BYP, "x7_dual_wb_same");
                    ready(5'd7, 1'b1, "x7_ready");
                end
                1: begin issue(5'd7); rd(0, 5'd7, 32'h22, 1'b1, "x7_high_port_wins"); end
                2: begin
                    wb(0, 5'd7, 32'h33);
                    wb(1, 5'd7, 32'h44);
                    rd(1, 5'd7, BYP ? 32'h44 : 32'h0, BYP, "x7_dual_wb_pcnt1");
                end
                default: rd(1, 5'd7, 32'h44, 1'b1, "x7_pcnt_floor");
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    task automatic test_saturate();
        for (int k = 0; k < 6; k++) begin
            @(posedge clk_in); #1;
            idle();
            case (k)
                0, 1, 2: begin issue(5'd9); ready(5'd9, 1'b1, "x9_ready_below_max"); end
                3: begin
                    issue(5'd9);
                    ready(5'd9, 1'b0, "x9_ready_at_max");
                    rd(0, 5'd9, 32'h0, 1'b0, "x9_at_max");
                    rd(1, 5'd10, 32'h0, 1'b1, "x10_free");
                end
                4: begin
                    wb(0, 5'd9, 32'h99);
                    ready(5'd9, 1'b0, "x9_ready_state_only");
                    rd(0, 5'd9, 32'h0, 1'b0, "x9_wb_pcnt3");
                end
                default: begin
                    ready(5'd9, 1'b1, "x9_ready_after_wb");
                    rd(0, 5'd9, 32'h0, 1'b0, "x9_pcnt2");
                end
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    task automatic test_flush_x0();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            idle();
            case (k)
                0: begin
                    issue(5'd4);
                    flush_in = 1'b1;
                    wb(0, 5'd4, 32'h77);
                    rd(0, 5'd4, BYP ? 32'h77 : 32'h0, BYP, "x4_flush_cycle");
                    ready(5'd4, 1'b1, "x4_ready");
                end
                1: begin
                    rd(0, 5'd4, 32'h77, 1'b1, "x4_after_flush");
                    rd(1, 5'd9, 32'h99, 1'b1, "x9_cleared_by_flush");
                    ready(5'd9, 1'b1, "x9_ready_after_flush");
                end
                2: begin
                    wb(0, 5'd0, 32'h55);
                    issue(5'd0);
                    rd(0, 5'd0, 32'h0, 1'b1, "x0_wb_same");
                    ready(5'd0, 1'b1, "x0_ready");
                end
                default: rd(0, 5'd0, 32'h0, 1'b1, "x0_after_wb");
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    task automatic test_issue_wb_same();
        for (int k = 0; k < 5; k++) begin
            @(posedge clk_in); #1;
            idle();
            case (k)
                0: issue(5'd2);
                1: begin
                    issue(5'd2);
                    wb(1, 5'd2, 32'hAB);
                    ready(5'd2, 1'b1, "x2_ready");
                    rd(0, 5'd2, BYP ? 32'hAB : 32'h0, BYP, "x2_issue_and_wb");
                end
                2: rd(0, 5'd2, 32'h0, 1'b0, "x2_pcnt_stays_1");
                3: begin
                    wb(0, 5'd2, 32'hCD);
                    rd(0, 5'd2, BYP ? 32'hCD : 32'h0, BYP, "x2_final_wb");
                end
                default: rd(0, 5'd2, 32'hCD, 1'b1, "x2_settled");
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #1;
            idle();
            if (k == 2) rst_n_in = 1'b0;
            if (k == 3) rst_n_in = 1'b1;
            case (k)
                0: issue(5'd6);
                1: rd(0, 5'd6, 32'h0, 1'b0, "x6_pending");
                2: begin
                    rd(0, 5'd6, 32'h0, 1'b0, "x6_in_reset");
                    rd(1, 5'd7, 32'h0, 1'b0, "x7_in_reset");
                    ready(5'd6, 1'b0, "ready_in_reset");
                end
                default: begin
                    rd(0, 5'd6, 32'h0, 1'b1, "x6_pending_discarded");
                    rd(1, 5'd7, 32'h0, 1'b1, "x7_data_cleared");
                    ready(5'd6, 1'b1, "ready_after_reset");
                end
            endcase
            @(negedge clk_in);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == NRP) begin act_d = '0; act_ok = iss_ready_out; end
                else begin act_d = rd_data_out[e.port*XLEN +: XLEN]; act_ok = rd_ok_out[e.port]; end
                checks++;
                if (act_d !== e.data || act_ok !== e.ok) begin
                    failures++;
                    $display("FAIL %s: got data=%h ok=%b, want data=%h ok=%b", e.name, act_d, act_ok, e.data, e.ok);
                end
            end
        end
    endtask

    initial begin
        rst_n_in = 1'b0;
        idle();
        test_reset();
        test_issue_wb();
        test_multi_wb();
        test_saturate();
        test_flush_x0();
        test_issue_wb_same();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
